// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address register and IDLE/RUN/DONE program-run FSM for the pipelined MIPS core.
// In RUN the next PC is chosen by priority: halt, EX branch, stall, ID jump, sequential.
module pc_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int OFF_W      = 16,
    parameter int JIDX_W     = 26,
    parameter int RESET_ADDR = 0,
    parameter int HALT_ADDR  = 19,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              start,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_base,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jmp_idx,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              flush,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  cycles
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] HALT_PC = ADDR_W'(HALT_ADDR);
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n, off_ext, br_pc, jmp_pc;
    logic [CNT_W-1:0]  cycles_n;
    logic              flush_n, start_q, launch;
    assign pc_plus1 = pc + ADDR_W'(1);
    assign br_pc    = br_base + off_ext;
    assign running  = state == RUN;
    assign done     = state == DONE;
    // A restart from DONE needs start to have been seen low first.
    assign launch   = start & ~start_q;
    generate
        if (OFF_W >= ADDR_W) begin : g_off_trunc
            assign off_ext = br_off[ADDR_W-1:0];
            if (OFF_W > ADDR_W) begin : g_off_hi
                logic unused_off_hi;
                assign unused_off_hi = ^br_off[OFF_W-1:ADDR_W];
            end
        end else begin : g_off_sext
            assign off_ext = {{(ADDR_W-OFF_W){br_off[OFF_W-1]}}, br_off};
        end
        if (JIDX_W >= ADDR_W) begin : g_jmp_trunc
            assign jmp_pc = jmp_idx[ADDR_W-1:0];
            if (JIDX_W > ADDR_W) begin : g_jmp_hi
                logic unused_jmp_hi;
                assign unused_jmp_hi = ^jmp_idx[JIDX_W-1:ADDR_W];
            end
        end else begin : g_jmp_page
            assign jmp_pc = {pc_plus1[ADDR_W-1:JIDX_W], jmp_idx};
        end
    endgenerate
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state   <= IDLE;
            pc      <= RST_PC;
            flush   <= 1'b0;
            cycles  <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            flush   <= flush_n;
            cycles  <= cycles_n;
            start_q <= start;
        end
    end
    always_comb begin
        state_n  = state;
        pc_n     = RST_PC;
        flush_n  = 1'b0;
        cycles_n = cycles;
        case (state)
            IDLE: begin
                state_n  = start ? RUN : IDLE;
                cycles_n = start ? '0 : cycles;
            end
            RUN: begin
                cycles_n = (&cycles) ? cycles : cycles + CNT_W'(1);
                if (pc == HALT_PC) begin
                    state_n = DONE;
                end else if (br_taken) begin
                    pc_n    = br_pc;
                    flush_n = 1'b1;
                end else if (stall) begin
                    pc_n = pc;
                end else if (jump) begin
                    pc_n    = jmp_pc;
                    flush_n = 1'b1;
                end else begin
                    pc_n = pc_plus1;
                end
            end
            DONE: begin
                state_n  = launch ? RUN : DONE;
                cycles_n = launch ? '0 : cycles;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer against a behavioural run model.
// A second instance with a 4-bit counter exercises cycle-count saturation.
`timescale 1ns/1ps
module tb_pc_sequencer;
    localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;
    logic        clk = 0, clr = 1, start = 0, stall = 0, br_taken = 0, jump = 0;
    logic [7:0]  br_base = '0;
    logic [15:0] br_off = '0;
    logic [25:0] jmp_idx = '0;
    logic [7:0]  pc, pc_plus1, pc_b, pcp1_b;
    logic        flush, running, done, flush_b, running_b, done_b;
    logic [15:0] cycles;
    logic [3:0]  cycles_b;
    typedef struct {int pc; int flush; int running; int done; int cycles; int cycles_b;} exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0;
    int m_st, m_pc, m_cyc, m_cyc_b, m_flush;
    bit m_prev;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .Clk(clk), .Clr(clr), .start(start), .stall(stall), .br_taken(br_taken),
        .br_base(br_base), .br_off(br_off), .jump(jump), .jmp_idx(jmp_idx),
        .pc(pc), .pc_plus1(pc_plus1), .flush(flush), .running(running), .done(done), .cycles(cycles)
    );
    pc_sequencer #(.CNT_W(4)) u_sat (
        .Clk(clk), .Clr(clr), .start(start), .stall(stall), .br_taken(br_taken),
        .br_base(br_base), .br_off(br_off), .jump(jump), .jmp_idx(jmp_idx),
        .pc(pc_b), .pc_plus1(pcp1_b), .flush(flush_b), .running(running_b), .done(done_b), .cycles(cycles_b)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_st = S_IDLE; m_pc = 0; m_cyc = 0; m_cyc_b = 0; m_flush = 0; m_prev = 0;
    endfunction

    function automatic void model_step();
        m_flush = 0;
        if (m_st == S_IDLE) begin
            if (start) begin m_st = S_RUN; m_cyc = 0; m_cyc_b = 0; end
        end else if (m_st == S_RUN) begin
            if (m_cyc < 65535) m_cyc++;
            if (m_cyc_b < 15) m_cyc_b++;
            if (m_pc == 19) begin
                m_pc = 0; m_st = S_DONE;
            end else if (br_taken) begin
                m_pc = (int'(br_base) + int'($signed(br_off))) & 255; m_flush = 1;
            end else if (!stall && jump) begin
                m_pc = int'(jmp_idx) & 255; m_flush = 1;
            end else if (!stall) begin
                m_pc = (m_pc + 1) % 256;
            end
        end else if (start && !m_prev) begin
            m_st = S_RUN; m_cyc = 0; m_cyc_b = 0;
        end
        m_prev = start;
    endfunction

    function automatic exp_t cur_exp();
        exp_t e;
        e.pc = m_pc; e.flush = m_flush; e.running = int'(m_st == S_RUN);
        e.done = int'(m_st == S_DONE); e.cycles = m_cyc; e.cycles_b = m_cyc_b;
        return e;
    endfunction

    task automatic cyc(input bit s, input bit st, input bit bt, input logic [7:0] bb,
                       input logic [15:0] bo, input bit j, input logic [25:0] ji);
        start = s; stall = st; br_taken = bt; br_base = bb; br_off = bo; jump = j; jmp_idx = ji;
        model_step();
        q.push_back(cur_exp());
        @(negedge clk);
    endtask

    task automatic idle_cyc(input bit s);
        cyc(s, 0, 0, 8'd0, 16'd0, 0, 26'd0);
    endtask

    // Clear is raised between edges; outputs must drop before the next clock.
    task automatic do_clr();
        clr = 1;
        #1;
        check("clr_pc", pc, 0);
        check("clr_flush", flush, 0);
        check("clr_running", running, 0);
        check("clr_done", done, 0);
        check("clr_cycles", cycles, 0);
        model_reset();
        start = 0; stall = 0; br_taken = 0; jump = 0;
        q.push_back(cur_exp());
        @(negedge clk);
        clr = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pc", pc, e.pc);
                check("pc_plus1", pc_plus1, (e.pc + 1) & 255);
                check("flush", flush, e.flush);
                check("running", running, e.running);
                check("done", done, e.done);
                check("cycles", cycles, e.cycles);
                check("pc_sat_inst", pc_b, e.pc);
                check("cycles_sat", cycles_b, e.cycles_b);
            end
        end
    end

    initial begin : stimulus
        bit s, st, bt, j;
        logic [7:0] bb;
        logic [15:0] bo;
        logic [25:0] ji;
        model_reset();
        @(negedge clk);
        do_clr();
        idle_cyc(1);
        for (int k = 0; k < 40 && m_st == S_RUN; k++) idle_cyc(1);
        repeat (5) idle_cyc(1);
        repeat (2) idle_cyc(0);
        idle_cyc(1);
        for (int k = 0; k < 40 && m_pc != 5; k++) idle_cyc(1);
        cyc(1, 0, 1, 8'd5, 16'hFFFD, 0, 26'd0);
        for (int k = 0; k < 40 && m_pc != 4; k++) idle_cyc(1);
        cyc(1, 1, 0, 8'd0, 16'd0, 1, 26'd9);
        cyc(1, 1, 1, 8'd4, 16'd3, 0, 26'd0);
        cyc(1, 0, 0, 8'd0, 16'd0, 1, 26'h3FFFFFD);
        for (int k = 0; k < 300 && m_st == S_RUN; k++)
            cyc(1, 0, m_pc == 19, 8'd100, 16'd1, m_pc == 19, 26'd50);
        idle_cyc(0);
        idle_cyc(1);
        for (int k = 0; k < 40 && m_pc != 7; k++) idle_cyc(1);
        do_clr();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_clr();
                continue;
            end
            if (m_st == S_IDLE) s = $urandom_range(0, 3) != 0;
            else if (m_st == S_DONE) s = ($urandom_range(0, 2) == 0) ? ~start : start;
            else s = 1'($urandom_range(0, 1));
            bt = $urandom_range(0, 7) == 0;
            st = $urandom_range(0, 3) == 0;
            j  = $urandom_range(0, 7) == 0;
            bb = 8'($urandom);
            bo = 16'($urandom);
            if ($urandom_range(0, 1) == 1) bo = {{12{bo[3]}}, bo[3:0]};
            ji = 26'($urandom);
            cyc(s, st, bt, bb, bo, j, ji);
        end
        idle_cyc(0);
        repeat (3) @(negedge clk);
        check("scoreboard_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
